// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: executes loads/stores on a req/gnt/rvalid bus,
// passes ALU results through, and produces registered MEM/WB writeback fields.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_i,
    input  logic        wb_en_i,
    input  logic        read_en_i,
    input  logic        update_en_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_en_o,
    output logic [4:0]  rd_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic             ld_wb_en_q, ld_wb_en_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic             wb_en_q, wb_en_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             misalign_q, misalign_d;
    logic             bus_err_q, bus_err_d;

    logic             is_mem_c;
    logic             misaligned_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [31:0]      lane_c;
    logic [31:0]      load_val_c;

    // Decode the incoming op: alignment, byte enables and lane-replicated store data
    always_comb begin
        is_mem_c = valid_i & (read_en_i | update_en_i);
        case (size_i)
            2'b00: begin
                misaligned_c = 1'b0;
                be_c         = 4'b0001 << result_i[1:0];
                wdata_c      = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                misaligned_c = result_i[0];
                be_c         = result_i[1] ? 4'b1100 : 4'b0011;
                wdata_c      = {2{store_data_i[15:0]}};
            end
            default: begin
                misaligned_c = |result_i[1:0];
                be_c         = 4'b1111;
                wdata_c      = store_data_i;
            end
        endcase
    end

    // Select the addressed lane of read data and sign/zero-extend it
    always_comb begin
        lane_c = dmem_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_val_c = uns_q ? {24'd0, lane_c[7:0]}
                                        : {{24{lane_c[7]}}, lane_c[7:0]};
            2'b01:   load_val_c = uns_q ? {16'd0, lane_c[15:0]}
                                        : {{16{lane_c[15]}}, lane_c[15:0]};
            default: load_val_c = dmem_rdata_i;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        ld_wb_en_d = ld_wb_en_q;
        ld_rd_d    = ld_rd_q;
        wb_en_d    = 1'b0;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_mem_c) begin
                    if (misaligned_c) begin
                        misalign_d = 1'b1;
                    end else begin
                        addr_d     = {result_i[31:2], 2'b00};
                        we_d       = ~read_en_i;
                        be_d       = be_c;
                        wdata_d    = wdata_c;
                        off_d      = result_i[1:0];
                        size_d     = size_i;
                        uns_d      = unsigned_i;
                        ld_wb_en_d = wb_en_i;
                        ld_rd_d    = rd_i;
                        req_d      = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_REQ;
                    end
                end else begin
                    wb_en_d   = valid_i & wb_en_i;
                    rd_d      = rd_i;
                    wb_data_d = result_i;
                end
            end
            S_REQ: begin
                if (dmem_gnt_i) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = S_IDLE;
                    end else if (dmem_rvalid_i) begin
                        wb_en_d   = ld_wb_en_q;
                        rd_d      = ld_rd_q;
                        wb_data_d = load_val_c;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    wb_en_d   = ld_wb_en_q;
                    rd_d      = ld_rd_q;
                    wb_data_d = load_val_c;
                    state_d   = S_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            ld_wb_en_q <= 1'b0;
            ld_rd_q    <= '0;
            wb_en_q    <= 1'b0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            ld_wb_en_q <= ld_wb_en_d;
            ld_rd_q    <= ld_rd_d;
            wb_en_q    <= wb_en_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign stall_o      = (state_q != S_IDLE);
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign wb_en_o      = wb_en_q;
    assign rd_o         = rd_q;
    assign wb_data_o    = wb_data_q;
    assign misalign_o   = misalign_q;
    assign bus_err_o    = bus_err_q;

endmodule
